// File: rtl/neighbor_builder.sv
// neighbor_builder: walks the face table in OBJ RAM and builds a per-vertex
// adjacency list in NBR RAM. Each vertex owns NBR_STRIDE words: word 0 holds
// the neighbor count, the rest hold neighbor indices. Only polygon edges are
// recorded, so triangles see every other vertex and larger faces see only
// their two edge neighbors.
// Optional statistics outputs (max_degree, insert_total) are compiled in when
// the macro NEIGHBOR_STATS_EN is defined.
module neighbor_builder #(
    parameter int ADDR_WIDTH = 9,
    parameter int NBR_STRIDE = 10,
    parameter int FACE_VERTS = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [ADDR_WIDTH-1:0] face_base,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_OBJ_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  bad_index
`ifdef NEIGHBOR_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  max_degree,
    output logic [31:0]           insert_total
`endif
);

    localparam int VW = $clog2(FACE_VERTS);
    localparam logic [CNT_WIDTH-1:0]  CAP      = CNT_WIDTH'(NBR_STRIDE - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(NBR_STRIDE);
    localparam logic [VW-1:0]         LAST_K   = VW'(FACE_VERTS - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLEAR  = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_FREAD  = 4'd3;
    localparam logic [3:0] S_CHECK  = 4'd4;
    localparam logic [3:0] S_PAIR   = 4'd5;
    localparam logic [3:0] S_RDCNT  = 4'd6;
    localparam logic [3:0] S_LATCH  = 4'd7;
    localparam logic [3:0] S_SCAN   = 4'd8;
    localparam logic [3:0] S_INSERT = 4'd9;
    localparam logic [3:0] S_INSCNT = 4'd10;
    localparam logic [3:0] S_NEXT   = 4'd11;
    localparam logic [3:0] S_FINISH = 4'd12;

    logic [3:0]            state_reg;
    logic [31:0]           vcount_reg;
    logic [31:0]           fcount_reg;
    logic [31:0]           face_idx_reg;
    logic [ADDR_WIDTH-1:0] face_addr_reg;
    logic [31:0]           clr_idx_reg;
    logic [ADDR_WIDTH-1:0] clr_addr_reg;
    logic [VW:0]           rd_idx_reg;
    logic [31:0]           v_reg [FACE_VERTS];
    logic [VW-1:0]         pair_reg;
    logic                  dir_reg;
    logic [31:0]           test_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [CNT_WIDTH:0]    sidx_reg;
    logic [CNT_WIDTH:0]    chk_idx_reg;
    logic                  chk_valid_reg;

    logic [VW-1:0]         next_k;
    logic [VW-1:0]         prev_k;
    logic [31:0]           curr_v;
    logic [31:0]           test_v;
    logic [ADDR_WIDTH-1:0] curr_base;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [FACE_VERTS-1:0] bad_vec;

    // Per-vertex index validity: 0 or beyond vertex_count marks the face bad.
    genvar gi;
    generate
        for (gi = 0; gi < FACE_VERTS; gi++) begin : g_bad
            assign bad_vec[gi] = (v_reg[gi] == 32'd0) || (v_reg[gi] > vcount_reg);
        end
    endgenerate

    assign next_k    = (pair_reg == LAST_K) ? '0 : pair_reg + VW'(1);
    assign prev_k    = (pair_reg == '0) ? LAST_K : pair_reg - VW'(1);
    assign curr_v    = v_reg[pair_reg];
    assign test_v    = dir_reg ? v_reg[prev_k] : v_reg[next_k];
    assign curr_base = (curr_v[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) * STRIDE_A;
    assign cnt_inc   = count_reg + CNT_WIDTH'(1);

    // RAM strobes and status decoded from the current state; IDLE drives all zero.
    always_comb begin
        RAM_OBJ_EN = 1'b0;
        RAM_OBJ_A  = '0;
        RAM_NBR_EN = 1'b0;
        RAM_NBR_WE = 4'b0000;
        RAM_NBR_A  = '0;
        RAM_NBR_Di = '0;
        busy       = (state_reg != S_IDLE) && (state_reg != S_FINISH);
        done       = (state_reg == S_FINISH);
        case (state_reg)
            S_CLEAR: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                RAM_NBR_A  = clr_addr_reg;
            end
            S_FREAD: begin
                if (rd_idx_reg < (VW+1)'(FACE_VERTS)) begin
                    RAM_OBJ_EN = 1'b1;
                    RAM_OBJ_A  = face_addr_reg + ADDR_WIDTH'(rd_idx_reg);
                end
            end
            S_RDCNT: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_A  = base_reg;
            end
            S_SCAN: begin
                if (sidx_reg <= {1'b0, count_reg}) begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_A  = base_reg + ADDR_WIDTH'(sidx_reg);
                end
            end
            S_INSERT: begin
                if (count_reg != CAP) begin
                    RAM_NBR_EN = 1'b1;
                    RAM_NBR_WE = 4'b1111;
                    RAM_NBR_A  = base_reg + ADDR_WIDTH'(count_reg) + ADDR_WIDTH'(1);
                    RAM_NBR_Di = test_reg;
                end
            end
            S_INSCNT: begin
                RAM_NBR_EN = 1'b1;
                RAM_NBR_WE = 4'b1111;
                RAM_NBR_A  = base_reg;
                RAM_NBR_Di = {{(32-CNT_WIDTH){1'b0}}, cnt_inc};
            end
            default: ;
        endcase
    end

    // Main sequencer: clear slots, fetch each face, then scan/insert every edge pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            vcount_reg    <= '0;
            fcount_reg    <= '0;
            face_idx_reg  <= '0;
            face_addr_reg <= '0;
            clr_idx_reg   <= '0;
            clr_addr_reg  <= '0;
            rd_idx_reg    <= '0;
            for (int i = 0; i < FACE_VERTS; i++) v_reg[i] <= '0;
            pair_reg      <= '0;
            dir_reg       <= 1'b0;
            test_reg      <= '0;
            base_reg      <= '0;
            count_reg     <= '0;
            sidx_reg      <= '0;
            chk_idx_reg   <= '0;
            chk_valid_reg <= 1'b0;
            overflow      <= 1'b0;
            bad_index     <= 1'b0;
`ifdef NEIGHBOR_STATS_EN
            max_degree    <= '0;
            insert_total  <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        vcount_reg    <= vertex_count;
                        fcount_reg    <= face_count;
                        face_addr_reg <= face_base;
                        face_idx_reg  <= '0;
                        clr_idx_reg   <= '0;
                        clr_addr_reg  <= '0;
                        overflow      <= 1'b0;
                        bad_index     <= 1'b0;
`ifdef NEIGHBOR_STATS_EN
                        max_degree    <= '0;
                        insert_total  <= '0;
`endif
                        state_reg     <= (vertex_count == 32'd0) ? S_FETCH : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_idx_reg == vcount_reg - 32'd1) begin
                        state_reg <= S_FETCH;
                    end else begin
                        clr_idx_reg  <= clr_idx_reg + 32'd1;
                        clr_addr_reg <= clr_addr_reg + STRIDE_A;
                    end
                end
                S_FETCH: begin
                    rd_idx_reg <= '0;
                    state_reg  <= (face_idx_reg == fcount_reg) ? S_FINISH : S_FREAD;
                end
                S_FREAD: begin
                    // Data for the word addressed last cycle arrives now.
                    if (rd_idx_reg != '0) v_reg[VW'(rd_idx_reg - (VW+1)'(1))] <= RAM_OBJ_Do;
                    if (rd_idx_reg == (VW+1)'(FACE_VERTS)) state_reg <= S_CHECK;
                    else                                   rd_idx_reg <= rd_idx_reg + (VW+1)'(1);
                end
                S_CHECK: begin
                    if (|bad_vec) begin
                        bad_index     <= 1'b1;
                        face_idx_reg  <= face_idx_reg + 32'd1;
                        face_addr_reg <= face_addr_reg + ADDR_WIDTH'(FACE_VERTS);
                        state_reg     <= S_FETCH;
                    end else begin
                        pair_reg  <= '0;
                        dir_reg   <= 1'b0;
                        state_reg <= S_PAIR;
                    end
                end
                S_PAIR: begin
                    test_reg  <= test_v;
                    base_reg  <= curr_base;
                    state_reg <= (test_v == curr_v) ? S_NEXT : S_RDCNT;
                end
                S_RDCNT: state_reg <= S_LATCH;
                S_LATCH: begin
                    count_reg     <= RAM_NBR_Do[CNT_WIDTH-1:0];
                    sidx_reg      <= (CNT_WIDTH+1)'(1);
                    chk_valid_reg <= 1'b0;
                    state_reg     <= (RAM_NBR_Do[CNT_WIDTH-1:0] == '0) ? S_INSERT : S_SCAN;
                end
                S_SCAN: begin
                    if (chk_valid_reg && (RAM_NBR_Do == test_reg)) begin
                        state_reg <= S_NEXT;
                    end else if (chk_valid_reg && (chk_idx_reg == {1'b0, count_reg})) begin
                        state_reg <= S_INSERT;
                    end else begin
                        chk_valid_reg <= (sidx_reg <= {1'b0, count_reg});
                        chk_idx_reg   <= sidx_reg;
                        sidx_reg      <= sidx_reg + (CNT_WIDTH+1)'(1);
                    end
                end
                S_INSERT: begin
                    if (count_reg == CAP) begin
                        overflow  <= 1'b1;
                        state_reg <= S_NEXT;
                    end else begin
                        state_reg <= S_INSCNT;
                    end
                end
                S_INSCNT: begin
`ifdef NEIGHBOR_STATS_EN
                    if (cnt_inc > max_degree) max_degree <= cnt_inc;
                    insert_total <= insert_total + 32'd1;
`endif
                    state_reg <= S_NEXT;
                end
                S_NEXT: begin
                    if (!dir_reg) begin
                        dir_reg   <= 1'b1;
                        state_reg <= S_PAIR;
                    end else begin
                        dir_reg <= 1'b0;
                        if (pair_reg == LAST_K) begin
                            pair_reg      <= '0;
                            face_idx_reg  <= face_idx_reg + 32'd1;
                            face_addr_reg <= face_addr_reg + ADDR_WIDTH'(FACE_VERTS);
                            state_reg     <= S_FETCH;
                        end else begin
                            pair_reg  <= next_k;
                            state_reg <= S_PAIR;
                        end
                    end
                end
                S_FINISH: state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_builder.sv
// Directed bench for neighbor_builder: three instances (default triangle,
// quad faces, and a 2-entry slot) each with its own OBJ/NBR RAM model.
module tb_neighbor_builder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [31:0] vc, fc;
    logic [8:0]  fbase;
    logic [2:0]  done_v, busy_v, ovf_v, bad_v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g
            logic [31:0] obj_mem [512];
            logic [31:0] nbr_mem [512];
            logic        obj_en, nbr_en;
            logic [8:0]  obj_a, nbr_a;
            logic [3:0]  nbr_we;
            logic [31:0] obj_do, nbr_do, nbr_di;
            logic        busy_w, done_w, ovf_w, bad_w;

            neighbor_builder #(
                .ADDR_WIDTH(9),
                .NBR_STRIDE((gi == 2) ? 3 : 10),
                .FACE_VERTS((gi == 1) ? 4 : 3),
                .CNT_WIDTH(4)
            ) u (
                .clk(clk), .rst_n(rst_n), .start(start_v[gi]),
                .vertex_count(vc), .face_count(fc), .face_base(fbase),
                .RAM_OBJ_Do(obj_do), .RAM_OBJ_EN(obj_en), .RAM_OBJ_A(obj_a),
                .RAM_NBR_Do(nbr_do), .RAM_NBR_EN(nbr_en), .RAM_NBR_WE(nbr_we),
                .RAM_NBR_A(nbr_a), .RAM_NBR_Di(nbr_di),
                .busy(busy_w), .done(done_w), .overflow(ovf_w), .bad_index(bad_w)
            );

            initial begin
                for (int i = 0; i < 512; i++) begin
                    obj_mem[i] = 32'd0;
                    nbr_mem[i] = 32'hdeadbeef;
                end
                obj_do = 32'd0;
                nbr_do = 32'd0;
            end

            always @(posedge clk) begin
                if (obj_en) obj_do <= obj_mem[obj_a];
                if (nbr_en) begin
                    nbr_do <= nbr_mem[nbr_a];
                    if (nbr_we == 4'hF) nbr_mem[nbr_a] <= nbr_di;
                end
            end

            assign done_v[gi] = done_w;
            assign busy_v[gi] = busy_w;
            assign ovf_v[gi]  = ovf_w;
            assign bad_v[gi]  = bad_w;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int idx, input logic [8:0] a);
        case (idx)
            0:       rd = g[0].nbr_mem[a];
            1:       rd = g[1].nbr_mem[a];
            default: rd = g[2].nbr_mem[a];
        endcase
    endfunction

    task automatic wobj(input int idx, input int addr, input logic [31:0] d);
        case (idx)
            0:       g[0].obj_mem[addr[8:0]] = d;
            1:       g[1].obj_mem[addr[8:0]] = d;
            default: g[2].obj_mem[addr[8:0]] = d;
        endcase
    endtask

    task automatic chk_slot(input string tag, input int idx, input int base, input int cnt,
                            input int n0, input int n1, input int n2);
        int exp_n [3];
        exp_n = '{n0, n1, n2};
        chk({tag, "_cnt"}, rd(idx, 9'(base)), 32'(cnt));
        for (int i = 0; i < cnt; i++)
            chk({tag, "_nbr"}, rd(idx, 9'(base + 1 + i)), 32'(exp_n[i]));
    endtask

    task automatic run(input int idx, input logic [31:0] vcn, input logic [31:0] fcn,
                       input logic [8:0] fb);
        int n;
        n = 0;
        @(negedge clk);
        vc = vcn; fc = fcn; fbase = fb;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v = '0;
        chk("busy_after_start", 32'(busy_v[idx]), 32'd1);
        while (!done_v[idx] && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_v[idx]), 32'd1);
        chk("busy_at_done", 32'(busy_v[idx]), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_v[idx]), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_v = '0; vc = '0; fc = '0; fbase = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_ovf", 32'(ovf_v[0]), 32'd0);
        chk("rst_bad", 32'(bad_v[0]), 32'd0);
        chk("rst_nbr_en", 32'(g[0].nbr_en), 32'd0);
        chk("rst_nbr_we", 32'(g[0].nbr_we), 32'd0);
        chk("rst_obj_en", 32'(g[0].obj_en), 32'd0);
        rst_n = 1'b1;

        // Single triangle (1,2,3)
        wobj(0, 0, 1); wobj(0, 1, 2); wobj(0, 2, 3);
        run(0, 3, 1, 9'd0);
        $display("tri: done, checking slots");
        chk("tri_ovf", 32'(ovf_v[0]), 32'd0);
        chk("tri_bad", 32'(bad_v[0]), 32'd0);
        chk_slot("tri_s1", 0, 0, 2, 2, 3, 0);
        chk_slot("tri_s2", 0, 10, 2, 3, 1, 0);
        chk_slot("tri_s3", 0, 20, 2, 1, 2, 0);

        // Two triangles sharing edge 1-3, face table at 16
        wobj(0, 16, 1); wobj(0, 17, 2); wobj(0, 18, 3);
        wobj(0, 19, 1); wobj(0, 20, 3); wobj(0, 21, 4);
        run(0, 4, 2, 9'd16);
        $display("two tris: done, checking slots");
        chk_slot("two_s1", 0, 0, 3, 2, 3, 4);
        chk_slot("two_s2", 0, 10, 2, 3, 1, 0);
        chk_slot("two_s3", 0, 20, 3, 1, 2, 4);
        chk_slot("two_s4", 0, 30, 2, 1, 3, 0);
        chk("two_ovf", 32'(ovf_v[0]), 32'd0);

        // Bad index: face (1,5,2) with vertex_count=4
        wobj(0, 32, 1); wobj(0, 33, 5); wobj(0, 34, 2);
        run(0, 4, 1, 9'd32);
        $display("bad face: done, checking flags");
        chk("bad_flag", 32'(bad_v[0]), 32'd1);
        chk("bad_ovf", 32'(ovf_v[0]), 32'd0);
        chk_slot("bad_s1", 0, 0, 0, 0, 0, 0);
        chk_slot("bad_s2", 0, 10, 0, 0, 0, 0);
        chk_slot("bad_s3", 0, 20, 0, 0, 0, 0);
        chk_slot("bad_s4", 0, 30, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("bad_sticky", 32'(bad_v[0]), 32'd1);

        // Reset during SCAN, then rerun the single triangle
        vc = 3; fc = 1; fbase = 9'd0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        chk("bad_cleared_on_start", 32'(bad_v[0]), 32'd0);
        n = 0;
        while (g[0].u.state_reg != 4'd8 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_scan", 32'(g[0].u.state_reg), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-scan");
        chk("arst_busy", 32'(busy_v[0]), 32'd0);
        chk("arst_done", 32'(done_v[0]), 32'd0);
        chk("arst_nbr_en", 32'(g[0].nbr_en), 32'd0);
        chk("arst_nbr_we", 32'(g[0].nbr_we), 32'd0);
        chk("arst_nbr_a", 32'(g[0].nbr_a), 32'd0);
        chk("arst_nbr_di", g[0].nbr_di, 32'd0);
        chk("arst_obj_en", 32'(g[0].obj_en), 32'd0);
        chk("arst_obj_a", 32'(g[0].obj_a), 32'd0);
        chk("arst_ovf", 32'(ovf_v[0]), 32'd0);
        chk("arst_bad", 32'(bad_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 3, 1, 9'd0);
        $display("rerun tri: done, checking slots");
        chk_slot("rer_s1", 0, 0, 2, 2, 3, 0);
        chk_slot("rer_s2", 0, 10, 2, 3, 1, 0);
        chk_slot("rer_s3", 0, 20, 2, 1, 2, 0);

        // Quad (1,2,3,4): edge neighbors only
        wobj(1, 0, 1); wobj(1, 1, 2); wobj(1, 2, 3); wobj(1, 3, 4);
        run(1, 4, 1, 9'd0);
        $display("quad: done, checking slots");
        chk_slot("quad_s1", 1, 0, 2, 2, 4, 0);
        chk_slot("quad_s2", 1, 10, 2, 3, 1, 0);
        chk_slot("quad_s3", 1, 20, 2, 4, 2, 0);
        chk_slot("quad_s4", 1, 30, 2, 1, 3, 0);
        chk("quad_flags", {30'd0, ovf_v[1], bad_v[1]}, 32'd0);

        // Stride 3 (capacity 2): vertex 1 sees 2, 3, 4 -> overflow
        wobj(2, 0, 1); wobj(2, 1, 2); wobj(2, 2, 3);
        wobj(2, 3, 1); wobj(2, 4, 3); wobj(2, 5, 4);
        run(2, 4, 2, 9'd0);
        $display("overflow: done, checking slots");
        chk("ovf_flag", 32'(ovf_v[2]), 32'd1);
        chk("ovf_bad", 32'(bad_v[2]), 32'd0);
        chk_slot("ovf_s1", 2, 0, 2, 2, 3, 0);
        chk_slot("ovf_s4", 2, 9, 2, 1, 3, 0);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(ovf_v[2]), 32'd1);

        // Empty run (vertex_count=0, face_count=0) clears the sticky flag
        run(2, 0, 0, 9'd0);
        $display("empty run: done");
        chk("ovf_cleared", 32'(ovf_v[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
- Parametrised successor of the triangle neighbor-list builder used ahead of subdivision.
- Walks the face table in OBJ RAM and builds a per-vertex adjacency list in NBR RAM.
- Generalised vs. previous generation: configurable address, index and count widths; polygon faces of FACE_VERTS vertices with edge-only adjacency; explicit face base address; asynchronous reset; sticky overflow and bad-index error reporting; done pulse.
- Runs before the edge-point and vertex-point stages.

Parameters:
- ADDR_WIDTH, 9: RAM address width, both RAMs.
- NBR_STRIDE, 10: words per vertex slot in NBR RAM. Word 0 holds the count; words 1..NBR_STRIDE-1 hold neighbors. Capacity is NBR_STRIDE-1.
- FACE_VERTS, 3: vertices per face. Legal range 3..8.
- CNT_WIDTH, 4: width of the stored neighbor count. Must satisfy 2^CNT_WIDTH > NBR_STRIDE-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled in IDLE only.
- vertex_count  in  32  vertices (1-based indices 1..vertex_count).
- face_count  in  32  faces to process.
- face_base  in  ADDR_WIDTH  OBJ RAM address of the first face index word.
- RAM_OBJ_Do  in  32  OBJ read data.
- RAM_OBJ_EN  out  1  OBJ enable.
- RAM_OBJ_A  out  ADDR_WIDTH  OBJ address.
- RAM_NBR_Do  in  32  NBR read data.
- RAM_NBR_EN  out  1  NBR enable.
- RAM_NBR_WE  out  4  NBR byte write enables; 4'b1111 for a write, else 0.
- RAM_NBR_A  out  ADDR_WIDTH  NBR address.
- RAM_NBR_Di  out  32  NBR write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse on completion.
- overflow  out  1  sticky: a neighbor was dropped because its list was full.
- bad_index  out  1  sticky: a face contained index 0 or an index > vertex_count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All RAM outputs 0 (EN=0, WE=0, A=0, Di=0).
  - busy=0, done=0, overflow=0, bad_index=0.
  - Reset mid-operation abandons the work; NBR contents are then undefined.
- RAM timing: synchronous, 1-cycle read latency. Address presented in cycle N yields Do in cycle N+1.
- Slot layout: slot base for vertex v is (v-1)*NBR_STRIDE, computed at ADDR_WIDTH bits, truncated. Count is stored in Di[CNT_WIDTH-1:0] with upper bits 0.
- IDLE:
  - done=0.
  - On start=1: clear overflow and bad_index, set busy=1, go to CLEAR.
  - start while busy is ignored.
- CLEAR: writes 0 to the count word of vertices 1..vertex_count, one per cycle (vertex_count cycles). vertex_count=0 skips directly to FETCH.
- FETCH:
  - If faces done == face_count, go to FINISH.
  - Otherwise read FACE_VERTS consecutive words from face_base + f*FACE_VERTS into v[0..FACE_VERTS-1]. Reads are pipelined, FACE_VERTS+1 cycles.
  - If any v[k] is 0 or > vertex_count: set bad_index, skip the face, increment f.
- Pair loop: for k = 0..FACE_VERTS-1, curr=v[k], tests in order v[(k+1) mod FACE_VERTS] then v[(k-1) mod FACE_VERTS].
  - Triangles therefore record all other vertices; quads and larger record only edge neighbors.
  - If test == curr (degenerate face), skip the pair.
- READ_COUNT: address the slot base; latch the count the next cycle.
- SCAN:
  - Read words base+1..base+count, one address per cycle, comparing pipelined data to test.
  - On a match, go to NEXT_PAIR.
  - If count=0, or all words were checked without a match, go to INSERT.
- INSERT:
  - If count == NBR_STRIDE-1: set overflow, skip.
  - Otherwise write test to base+count+1 in one cycle, then write count+1 to base in the next cycle, then WE=0.
- NEXT_PAIR: advance the pair. After the last pair, increment f and return to FETCH.
- FINISH: busy=0, done=1 for one cycle, go to IDLE.
- Arithmetic: face address computed at ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH.
- Simultaneous events: start asserted in the same cycle done is asserted is ignored; a new start is accepted from the following IDLE cycle.

Optional Feature:
- Macro: NEIGHBOR_STATS_EN.
- When defined, add outputs:
  - max_degree [CNT_WIDTH-1:0]: largest count written.
  - insert_total [31:0]: number of successful inserts.
  - Both are cleared on start and on reset, and hold their values after done.
- When undefined, the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Single triangle (1,2,3), vertex_count=3, face_count=1, defaults -> slot1={2,2,3}, slot2={2,3,1}, slot3={2,1,2}; done pulses once; no flags set.
- Two triangles (1,2,3),(1,3,4) sharing edge 1-3 -> slot1 count 3 {2,3,4}; slot3 count 3 {1,2,4}; no duplicate entries.
- FACE_VERTS=4, quad (1,2,3,4) -> each count 2; slot1={2,4}, slot2={3,1}; diagonals 1-3 and 2-4 absent.
- NBR_STRIDE=3, vertex 1 in faces giving 3 distinct neighbors -> slot1 count 2 (first two inserted); overflow=1 and stays 1 until the next start.
- Face (1,5,2) with vertex_count=4 -> bad_index=1; face skipped; all counts 0; done still pulses.
- rst_n pulled low during SCAN -> all outputs 0 immediately without waiting for a clock edge; a subsequent start reruns the single-triangle case correctly.
